// File: rtl/adc_i2c_pkg.sv
// Shared types and constants for the in-fabric ADC I2C target emulator.
package adc_i2c_pkg;

    localparam int          BYTE_W     = 8;
    localparam int          SAMPLE_W   = 12;
    localparam int          TX_W       = 16;
    localparam logic [6:0]  DEF_ADDR   = 7'b0101000;
    localparam logic [3:0]  PAD_NIBBLE = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_TX_BYTE,
        ST_TX_ACKCHK,
        ST_RX_BYTE,
        ST_RX_ACK,
        ST_WAIT_STOP
    } state_e;

    // Two-byte read frame: high byte carries the pad nibble above sample[11:8].
    function automatic logic [TX_W-1:0] tx_word(input logic [SAMPLE_W-1:0] s);
        return {PAD_NIBBLE, s};
    endfunction

endpackage

// File: rtl/adc_i2c_target_if.sv
// Two-wire bus as seen by the target: sampled SCL/SDA in, open-drain SDA enable out.
interface adc_i2c_if;
    logic scl;
    logic sda;
    logic sda_oe;

    modport target (input scl, input sda, output sda_oe);
    modport master (output scl, output sda, input sda_oe);
endinterface

// File: rtl/adc_i2c_target_line_sync.sv
// SCL/SDA synchronizers plus history flops; emits SCL edge and START/STOP pulses.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_hist_q, sda_hist_q;
    logic                   scl_s;

    // Reset to the idle-bus level so release of reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_o;
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_o      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise_o = scl_s & ~scl_hist_q;
    assign scl_fall_o = ~scl_s & scl_hist_q;
    assign start_o    = scl_s & scl_hist_q & sda_hist_q & ~sda_o;
    assign stop_o     = scl_s & scl_hist_q & ~sda_hist_q & sda_o;

endmodule

// File: rtl/adc_i2c_target.sv
// I2C target emulating a 12-bit ADC: two-byte sample reads, one-byte config writes.
module adc_i2c_target
    import adc_i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = DEF_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    adc_i2c_if.target           bus,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                sample_valid_i,
    output logic [BYTE_W-1:0]   config_o,
    output logic                config_valid_o,
    output logic                busy_o,
    output logic                addr_hit_o
);

    logic sda_s, scl_rise, scl_fall, start_p, stop_p;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (bus.scl),
        .sda_i      (bus.sda),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_p),
        .stop_o     (stop_p)
    );

    state_e              state_q, state_d;
    logic [2:0]          bitcnt_q, bitcnt_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic [TX_W-1:0]     tx_q, tx_d;
    logic [SAMPLE_W-1:0] hold_q, hold_d, hold_next;
    logic [BYTE_W-1:0]   cfg_q, cfg_d;
    logic                oe_q, oe_d;
    logic                phase_q, phase_d;
    logic                rw_q, rw_d;
    logic                cfg_vld_q, cfg_vld_d;
    logic                hit_q, hit_d;
    logic                busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            hold_q    <= '0;
            cfg_q     <= '0;
            oe_q      <= 1'b0;
            phase_q   <= 1'b0;
            rw_q      <= 1'b0;
            cfg_vld_q <= 1'b0;
            hit_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            hold_q    <= hold_d;
            cfg_q     <= cfg_d;
            oe_q      <= oe_d;
            phase_q   <= phase_d;
            rw_q      <= rw_d;
            cfg_vld_q <= cfg_vld_d;
            hit_q     <= hit_d;
            busy_q    <= busy_d;
        end
    end

    // phase_q marks the second half of a two-step state: the ACK drive period,
    // or an ACK already seen in TX_ACKCHK waiting for the fall to drive the next byte.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        cfg_d     = cfg_q;
        oe_d      = oe_q;
        phase_d   = phase_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        cfg_vld_d = 1'b0;
        hit_d     = 1'b0;
        hold_next = sample_valid_i ? sample_i : hold_q;
        hold_d    = hold_next;

        if (stop_p) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            phase_d = 1'b0;
            busy_d  = 1'b0;
        end else if (start_p) begin
            state_d  = ST_ADDR;
            bitcnt_d = 3'd7;
            oe_d     = 1'b0;
            phase_d  = 1'b0;
            busy_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: if (scl_rise) begin
                    shift_d = {shift_q[BYTE_W-2:0], sda_s};
                    if (bitcnt_q == 3'd0) begin
                        if (shift_d[7:1] == ADDR) begin
                            state_d = ST_ADDR_ACK;
                            hit_d   = 1'b1;
                            rw_d    = sda_s;
                            phase_d = 1'b0;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q - 3'd1;
                    end
                end
                ST_ADDR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        oe_d    = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        phase_d  = 1'b0;
                        bitcnt_d = 3'd7;
                        if (rw_q) begin
                            tx_d    = tx_word(hold_next);
                            oe_d    = ~tx_d[TX_W-1];
                            state_d = ST_TX_BYTE;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = ST_RX_BYTE;
                        end
                    end
                end
                // Rotating the 16-bit word makes the high/low pair wrap for free.
                ST_TX_BYTE: if (scl_fall) begin
                    tx_d = {tx_q[TX_W-2:0], tx_q[TX_W-1]};
                    if (bitcnt_q == 3'd0) begin
                        oe_d    = 1'b0;
                        phase_d = 1'b0;
                        state_d = ST_TX_ACKCHK;
                    end else begin
                        bitcnt_d = bitcnt_q - 3'd1;
                        oe_d     = ~tx_d[TX_W-1];
                    end
                end
                ST_TX_ACKCHK: begin
                    if (scl_rise) begin
                        if (sda_s) state_d = ST_WAIT_STOP;
                        else       phase_d = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        phase_d  = 1'b0;
                        bitcnt_d = 3'd7;
                        oe_d     = ~tx_q[TX_W-1];
                        state_d  = ST_TX_BYTE;
                    end
                end
                ST_RX_BYTE: if (scl_rise) begin
                    shift_d = {shift_q[BYTE_W-2:0], sda_s};
                    if (bitcnt_q == 3'd0) begin
                        cfg_d     = shift_d;
                        cfg_vld_d = 1'b1;
                        phase_d   = 1'b0;
                        state_d   = ST_RX_ACK;
                    end else begin
                        bitcnt_d = bitcnt_q - 3'd1;
                    end
                end
                ST_RX_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        oe_d    = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        oe_d     = 1'b0;
                        phase_d  = 1'b0;
                        bitcnt_d = 3'd7;
                        state_d  = ST_RX_BYTE;
                    end
                end
                ST_WAIT_STOP: oe_d = 1'b0;
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe     = oe_q;
    assign config_o       = cfg_q;
    assign config_valid_o = cfg_vld_q;
    assign busy_o         = busy_q;
    assign addr_hit_o     = hit_q;

endmodule

// File: tb/tb_adc_i2c_target.sv
// Bench for adc_i2c_target: bit-banged I2C master plus queue scoreboard.
module tb_adc_i2c_target;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic [11:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic [7:0]  config_o;
    logic        config_valid, busy, addr_hit;

    adc_i2c_if bus();
    assign bus.scl = scl_m;
    assign bus.sda = sda_m & ~bus.sda_oe;

    adc_i2c_target #(.ADDR(7'h28), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .sample_i       (sample),
        .sample_valid_i (sample_valid),
        .config_o       (config_o),
        .config_valid_o (config_valid),
        .busy_o         (busy),
        .addr_hit_o     (addr_hit)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int oe_cnt = 0;
    bit         exp_hit_q[$];
    bit         exp_ack_q[$], obs_ack_q[$];
    logic [7:0] exp_rd_q[$], obs_rd_q[$], exp_cfg_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic q();
        repeat (4) @(negedge clk);
    endtask

    task automatic strobe(input logic [11:0] v);
        @(negedge clk);
        sample = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; q();
        scl_m = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    task automatic send_bit(input bit b);
        sda_m = b; q();
        scl_m = 1'b1; q(); q();
        scl_m = 1'b0; q();
    endtask

    task automatic write_byte(input logic [7:0] b, input bit exp_ack);
        bit ack;
        exp_ack_q.push_back(exp_ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        ack = bus.sda; q();
        scl_m = 1'b0; q();
        obs_ack_q.push_back(ack);
    endtask

    task automatic read_byte(input logic [7:0] exp_b, input bit mack);
        logic [7:0] b;
        exp_rd_q.push_back(exp_b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            q();
            scl_m = 1'b1; q();
            b[i] = bus.sda; q();
            scl_m = 1'b0; q();
        end
        obs_rd_q.push_back(b);
        send_bit(mack);
        sda_m = 1'b1;
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents a result.
    initial forever begin
        @(negedge clk);
        if (bus.sda_oe) oe_cnt++;
        if (addr_hit) begin
            chk("addr_hit_expected", int'(exp_hit_q.size() != 0), 1);
            if (exp_hit_q.size() != 0) void'(exp_hit_q.pop_front());
        end
        if (config_valid)
            chk("config_out", int'(config_o),
                exp_cfg_q.size() != 0 ? int'(exp_cfg_q.pop_front()) : 'h1FF);
        while (obs_ack_q.size() != 0)
            chk("ack_bit", int'(obs_ack_q.pop_front()),
                exp_ack_q.size() != 0 ? int'(exp_ack_q.pop_front()) : 2);
        while (obs_rd_q.size() != 0)
            chk("read_byte", int'(obs_rd_q.pop_front()),
                exp_rd_q.size() != 0 ? int'(exp_rd_q.pop_front()) : 'h1FF);
    end

    initial begin
        int oe_before;
        repeat (5) @(negedge clk);
        chk("rst_sda_oe", int'(bus.sda_oe), 0);
        chk("rst_config", int'(config_o), 0);
        chk("rst_cfg_valid", int'(config_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_addr_hit", int'(addr_hit), 0);
        rst_n = 1'b1;
        q();

        // Read 0x0ABC: ACK byte 1, NACK byte 2.
        strobe(12'hABC);
        exp_hit_q.push_back(1'b1);
        i2c_start();
        chk("busy_after_start", int'(busy), 1);
        write_byte(8'h51, 1'b0);
        read_byte(8'h0A, 1'b0);
        read_byte(8'hBC, 1'b1);
        chk("oe_after_nack", int'(bus.sda_oe), 0);
        i2c_stop();
        q();
        chk("busy_after_stop", int'(busy), 0);

        // Wrong address: never drives SDA until STOP.
        oe_before = oe_cnt;
        i2c_start();
        write_byte(8'h52, 1'b1);
        write_byte(8'h00, 1'b1);
        i2c_stop();
        q();
        chk("wrong_addr_oe_cycles", oe_cnt - oe_before, 0);

        // Config write.
        exp_hit_q.push_back(1'b1);
        exp_cfg_q.push_back(8'h5A);
        i2c_start();
        write_byte(8'h50, 1'b0);
        write_byte(8'h5A, 1'b0);
        i2c_stop();
        q();
        chk("config_after_write", int'(config_o), 'h5A);

        // Four-byte read; a new sample mid-transfer must not disturb it.
        strobe(12'h123);
        exp_hit_q.push_back(1'b1);
        i2c_start();
        write_byte(8'h51, 1'b0);
        read_byte(8'h01, 1'b0);
        fork
            read_byte(8'h23, 1'b0);
            begin
                repeat (20) @(negedge clk);
                strobe(12'hFFF);
            end
        join
        read_byte(8'h01, 1'b0);
        read_byte(8'h23, 1'b1);
        i2c_stop();
        exp_hit_q.push_back(1'b1);
        i2c_start();
        write_byte(8'h51, 1'b0);
        read_byte(8'h0F, 1'b0);
        read_byte(8'hFF, 1'b1);
        i2c_stop();

        // Repeated START: write 0x11 then read.
        exp_hit_q.push_back(1'b1);
        exp_cfg_q.push_back(8'h11);
        exp_hit_q.push_back(1'b1);
        i2c_start();
        write_byte(8'h50, 1'b0);
        write_byte(8'h11, 1'b0);
        i2c_start();
        write_byte(8'h51, 1'b0);
        read_byte(8'h0F, 1'b0);
        read_byte(8'hFF, 1'b1);
        i2c_stop();
        q();
        chk("config_after_rstart", int'(config_o), 'h11);

        // Reset while the target drives bit 0 of the low byte (0xBC, bit 0 = 0).
        strobe(12'hABC);
        exp_hit_q.push_back(1'b1);
        i2c_start();
        write_byte(8'h51, 1'b0);
        read_byte(8'h0A, 1'b0);
        for (int i = 0; i < 7; i++) begin
            q();
            scl_m = 1'b1; q(); q();
            scl_m = 1'b0; q();
        end
        chk("oe_drive_bit0", int'(bus.sda_oe), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_oe", int'(bus.sda_oe), 0);
        chk("rst_mid_config", int'(config_o), 0);
        chk("rst_mid_busy", int'(busy), 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        q();
        strobe(12'h5A5);
        exp_hit_q.push_back(1'b1);
        i2c_start();
        write_byte(8'h51, 1'b0);
        read_byte(8'h05, 1'b0);
        read_byte(8'hA5, 1'b1);
        i2c_stop();

        repeat (20) @(negedge clk);
        chk("pending_addr_hits", exp_hit_q.size(), 0);
        chk("pending_configs", exp_cfg_q.size(), 0);
        chk("pending_reads", exp_rd_q.size(), 0);
        chk("pending_acks", exp_ack_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
